// File: rtl/red_comparador_serial_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM states and p/q meaning.
package red_comparador_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // {p,q}: p marks A>B decided, q marks A<B decided, neither means equal so far.
  localparam logic [1:0] PQ_EQUAL = 2'b00;
  localparam logic [1:0] PQ_GT    = 2'b10;
  localparam logic [1:0] PQ_LT    = 2'b01;

endpackage

// File: rtl/red_celda_k.sv
// K-bit MSB-first cascade of typical comparator cells; a decided p or q is sticky.
module red_celda_k #(
  parameter int unsigned K = 1
) (
  input  logic         p_in,
  input  logic         q_in,
  input  logic [K-1:0] ai,
  input  logic [K-1:0] bi,
  output logic         p_out,
  output logic         q_out
);

  always_comb begin
    logic p;
    logic q;
    logic p_n;
    logic q_n;
    p   = p_in;
    q   = q_in;
    p_n = p_in;
    q_n = q_in;
    for (int i = int'(K) - 1; i >= 0; i--) begin
      p_n = p | (~q & ai[i] & ~bi[i]);
      q_n = q | (~p & ~ai[i] & bi[i]);
      p   = p_n;
      q   = q_n;
    end
    p_out = p;
    q_out = q;
  end

endmodule

// File: rtl/red_comparador_serial.sv
// Multi-cycle magnitude comparator: latches A/B on start, resolves K bits per clock MSB-first.
module red_comparador_serial
  import red_comparador_serial_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned K          = 1,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  localparam int unsigned NS = N / K;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
  // Flipping the MSB maps two's complement onto offset binary, so the unsigned chain applies.
  localparam logic [N-1:0] MSB_FLIP = (SIGNED != 0) ? (N'(1) << (N - 1)) : '0;

  state_t          state;
  logic [N-1:0]    ra;
  logic [N-1:0]    rb;
  logic [CW-1:0]   cnt;
  logic            p;
  logic            q;
  logic            p_nx;
  logic            q_nx;
  logic [K-1:0]    sa;
  logic [K-1:0]    sb;

  assign sa = ra[32'(cnt) * K +: K];
  assign sb = rb[32'(cnt) * K +: K];

  red_celda_k #(.K(K)) u_celda (
    .p_in  (p),
    .q_in  (q),
    .ai    (sa),
    .bi    (sb),
    .p_out (p_nx),
    .q_out (q_nx)
  );

  // Control FSM, operand registers, slice counter and registered result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      p     <= 1'b0;
      q     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a ^ MSB_FLIP;
            rb    <= b ^ MSB_FLIP;
            p     <= 1'b0;
            q     <= 1'b0;
            cnt   <= CW'(NS - 1);
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          p <= p_nx;
          q <= q_nx;
          if ((cnt == '0) || ((EARLY_EXIT != 0) && (p_nx | q_nx))) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          gt    <= ({p, q} == PQ_GT);
          lt    <= ({p, q} == PQ_LT);
          eq    <= ({p, q} == PQ_EQUAL);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
